wshb_fb_responder: RTL

Single-clock Wishbone classic slave that emulates the frame-buffer memory read by the VGA controller's Wishbone master. Holds an inferred RAM of 32-bit words and serves byte-addressed reads and byte-selectable writes with a fixed, parameterised number of wait states. Errors on misaligned or out-of-range accesses. Used as the memory model in video-path benches, and as an on-chip frame store for small resolutions.

---
 rtl/wshb_fb_responder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/wshb_fb_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wshb_fb_responder                                                          |
// | Wishbone classic slave frame-buffer RAM with fixed wait states and errors. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module wshb_fb_responder #(
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [3:0]  sel,
  input  logic [31:0] dat_ms,
  input  logic [2:0]  cti,
  input  logic [1:0]  bte,
  output logic [31:0] dat_sm,
  output logic        ack,
  output logic        err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int         c_AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] c_WS      = 4'(WAIT_STATES);
  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_WAIT = 2'd1;
  localparam logic [1:0] c_ST_RESP = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [3:0]      r_cnt;
  logic            r_we;
  logic [31:0]     r_adr;
  logic [3:0]      r_sel;
  logic [31:0]     r_dat;
  logic            r_ack;
  logic            r_err;
  logic [31:0]     r_dat_sm;
  logic [15:0]     r_rd_count;
  logic [15:0]     r_wr_count;
  logic [31:0]     r_mem [MEM_DEPTH];

  logic            w_req;
  logic            w_capture;
  logic            w_enter_resp;
  logic            w_eff_we;
  logic [31:0]     w_eff_adr;
  logic [3:0]      w_eff_sel;
  logic [31:0]     w_eff_dat;
  logic            w_bad;
  logic [c_AW-1:0] w_idx;
  logic            w_do_wr;
  logic            w_do_rd;
  logic            w_unused;

  assign w_req    = cyc & stb;
  assign w_unused = ^{cti, bte};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE: if (w_req) w_next = (c_WS == 4'd0) ? c_ST_RESP : c_ST_WAIT;
      c_ST_WAIT: begin
        if (!w_req)              w_next = c_ST_IDLE;
        else if (r_cnt == 4'd1)  w_next = c_ST_RESP;
      end
      c_ST_RESP: w_next = c_ST_IDLE;
      default:   w_next = c_ST_IDLE;
    endcase
  end

  // Output/control decode. With zero wait states the access is performed at the
  // capture edge itself, so the live bus is used instead of the latched copy.
  always_comb begin
    w_capture    = (r_state == c_ST_IDLE) && w_req;
    w_enter_resp = (r_state != c_ST_RESP) && (w_next == c_ST_RESP);
    if (r_state == c_ST_IDLE) begin
      w_eff_we  = we;
      w_eff_adr = adr;
      w_eff_sel = sel;
      w_eff_dat = dat_ms;
    end else begin
      w_eff_we  = r_we;
      w_eff_adr = r_adr;
      w_eff_sel = r_sel;
      w_eff_dat = r_dat;
    end
    w_bad   = (w_eff_adr[1:0] != 2'b00) ||
              ({2'b00, w_eff_adr[31:2]} >= 32'(MEM_DEPTH));
    w_idx   = w_eff_adr[c_AW+1:2];
    w_do_wr = w_enter_resp && !w_bad && w_eff_we;
    w_do_rd = w_enter_resp && !w_bad && !w_eff_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_adr      <= 32'd0;
      r_sel      <= 4'd0;
      r_dat      <= 32'd0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_dat_sm   <= 32'd0;
      r_rd_count <= 16'd0;
      r_wr_count <= 16'd0;
    end else begin
      if (w_capture) begin
        r_cnt <= c_WS;
        r_we  <= we;
        r_adr <= adr;
        r_sel <= sel;
        r_dat <= dat_ms;
      end else if (r_state == c_ST_WAIT && w_req) begin
        r_cnt <= r_cnt - 4'd1;
      end
      r_ack <= w_enter_resp && !w_bad;
      r_err <= w_enter_resp && w_bad;
      if (w_do_rd) r_dat_sm <= r_mem[w_idx];
      if (w_do_rd && r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
      if (w_do_wr && r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
    end
  end

  // RAM contents are deliberately not reset; writes are blocked while in reset.
  always_ff @(posedge clk) begin
    if (w_do_wr && rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (w_eff_sel[i]) r_mem[w_idx][8*i +: 8] <= w_eff_dat[8*i +: 8];
      end
    end
  end

  assign ack      = r_ack;
  assign err      = r_err;
  assign dat_sm   = r_dat_sm;
  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;

endmodule
`default_nettype wire
